ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 device-to-host serial receiver with a receive FIFO. It sits directly upstream of the keyboard bus wrapper.
- Samples the raw ps2_clk/ps2_data lines, deframes 11-bit frames and buffers the scan-code bytes.
- Presents the FIFO head as a byte with an active-low read-pop, a ready (non-empty) flag and a sticky overflow flag.
- ready doubles as the keyboard interrupt request.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (default 8).
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock; all logic on posedge clk.
clrn  input  1  asynchronous active-low reset.
ps2_clk  input  1  raw PS/2 clock line, asynchronous.
ps2_data  input  1  raw PS/2 data line, asynchronous.
rdn  input  1  active-low pop request, sampled at posedge clk.
data  output  8  FIFO head byte (show-ahead); 8'h00 when empty after reset.
ready  output  1  1 when FIFO holds at least one byte.
overflow  output  1  sticky: a completed frame was lost because the FIFO was full.
parity_err  output  1  sticky parity-error flag; present only with PS2_PARITY_CHK_EN.

Behaviour:
- Reset (clrn=0, async): FIFO pointers/count = 0, data=8'h00, ready=0, overflow=0, parity_err=0, receiver IDLE, bit counter=0, sync flops=1, timeout counter=0.
- Sync: ps2_clk passes through a 3-flop chain. A falling edge (fe) is sync[2:1]==2'b10. ps2_data passes through a 2-flop chain and is sampled on fe.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1) = 11 bits.
- FSM states:
  - IDLE: on fe with data=0, go to RECV with bitcnt=0. On fe with data=1, stay in IDLE (glitch, nothing stored).
  - RECV: on each fe, shift into shreg and increment bitcnt. On the fe that samples bit 10 (stop), go to DONE.
  - DONE (one cycle): if stop=1 (and parity OK when checking is enabled), push shreg[7:0]. Then return to IDLE. If stop=0, discard the frame silently.
- Timeout: in RECV, a counter increments every cycle and clears on fe. Reaching TIMEOUT_CYCLES-1 forces IDLE, clears bitcnt and pushes nothing.
- Latency: push occurs at the clk edge ending DONE. ready and data reflect the new byte in the next cycle, i.e. 2 clk after the stop-bit fe is detected.
- Pop: each posedge with rdn=0 and count>0 advances the read pointer by one. The caller holds rdn low for exactly one cycle per byte. Popping an empty FIFO is ignored; pointers are unchanged.
- data = mem[rptr] when count>0. data holds its last value when the FIFO is empty.
- Full: a push with count=2**FIFO_AW and no simultaneous pop drops the byte, sets overflow=1 and leaves the FIFO unchanged.
- Simultaneous push+pop:
  - When full: pop and push both execute, count unchanged, no overflow.
  - When empty: push executes, pop ignored, count becomes 1.
- Pointers wrap modulo 2**FIFO_AW. count is FIFO_AW+1 bits wide.
- overflow clears on reset or on any successful pop.
- Reset mid-frame: the partial frame is lost. The receiver resyncs on the next start bit after clrn deasserts.

Optional Feature:
PS2_PARITY_CHK_EN
- Defined:
  - In DONE, the XOR of D0..D7 and the parity bit must equal 1.
  - On mismatch, the byte is not pushed and parity_err is set. parity_err is sticky until reset or a successful pop.
  - The parity_err port exists.
- Undefined:
  - The parity bit is sampled and ignored.
  - Any frame with start=0 and stop=1 is pushed.
  - The parity_err port is absent.

Test Plan:
- Frame 0x1C with parity=0, stop=1 -> ready=1 two clk after the stop-bit fe, data=8'h1C. One-cycle rdn=0 -> ready=0 next cycle.
- Frames 0xF0, then 0x1C, no pops -> data=8'hF0. Pop -> data=8'h1C. Pop -> ready=0. Extra pop while empty -> no change.
- 9 frames (0x01..0x09) with default depth, no pops -> overflow=1, data=8'h01. Eight pops return 0x01..0x08 in order. overflow=0 after the first pop.
- 5 bits of a frame, then no ps2_clk activity for TIMEOUT_CYCLES, then a full frame 0x5A -> exactly one byte stored, 8'h5A.
- Frame 0x1C with stop=0 -> nothing stored, ready stays 0. With PS2_PARITY_CHK_EN, frame 0x1C with parity=1 -> nothing stored, parity_err=1.
- clrn pulsed low after bit 4 of a frame, then a full frame 0x76 -> all outputs at reset values during reset, then ready=1 with data=8'h76.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: read-side bus of the PS/2 receive FIFO.
//   rdn        active-low pop request (consumer -> FIFO)
//   data       FIFO head byte, show-ahead (FIFO -> consumer)
//   ready      FIFO non-empty; also the keyboard interrupt request
//   overflow   sticky: a completed frame was lost on a full FIFO
//   parity_err sticky parity error (only with PS2_PARITY_CHK_EN)
// master = FIFO side, slave = consumer side.
interface ps2_rx_fifo_if;
  logic       rdn;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
`ifdef PS2_PARITY_CHK_EN
  logic       parity_err;

  modport master (input rdn, output data, ready, overflow, parity_err);
  modport slave  (output rdn, input data, ready, overflow, parity_err);
`else
  modport master (input rdn, output data, ready, overflow);
  modport slave  (output rdn, input data, ready, overflow);
`endif
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a show-ahead receive FIFO.
// Samples raw ps2_clk/ps2_data, deframes 11-bit frames (start, D0..D7 LSB
// first, odd parity, stop) and buffers the data bytes.
// Optional feature macro: PS2_PARITY_CHK_EN (parity checking + parity_err).
// Ports:
//   clk       system clock, all logic on posedge
//   clrn      asynchronous active-low reset
//   ps2_clk   raw PS/2 clock line (asynchronous)
//   ps2_data  raw PS/2 data line (asynchronous)
//   bus       read-side bus (rdn, data, ready, overflow[, parity_err])
module ps2_rx_fifo #(
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_rx_fifo_if.master        bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = 8;
  localparam int unsigned SW    = 10;
  localparam int unsigned BCW   = 4;
  localparam int unsigned TCW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t             state;
  logic [2:0]         ps2_clk_sync;
  logic [1:0]         ps2_data_sync;
  logic [BCW-1:0]     bitcnt;
  logic [SW-1:0]      shreg;
  logic [TCW-1:0]     tcnt;

  logic [BW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [CW-1:0]      count;
  logic [BW-1:0]      data_q;
  logic               ready_q;
  logic               overflow_q;
  logic               perr_q;

  logic               fe;
  logic               parity_ok;
  logic               pop_do;
  logic               push_req;
  logic               push_do;
  logic               ovf_set;
  logic               perr_set;
  logic [CW-1:0]      count_next;
  logic [FIFO_AW-1:0] rptr_next;
  logic [BW-1:0]      head_next;

  // Falling edge of the synchronised PS/2 clock.
  assign fe = ps2_clk_sync[2] & ~ps2_clk_sync[1];

  // After ten shifts: shreg[7:0]=D7..D0, shreg[8]=parity, shreg[9]=stop.
`ifdef PS2_PARITY_CHK_EN
  assign parity_ok = ^shreg[8:0];
`else
  logic unused_parity;
  assign unused_parity = shreg[8];
  assign parity_ok     = 1'b1;
`endif

  // Input synchronisers and frame receiver FSM.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync  <= '1;
      ps2_data_sync <= '1;
      state         <= IDLE;
      bitcnt        <= '0;
      shreg         <= '0;
      tcnt          <= '0;
    end else begin
      ps2_clk_sync  <= {ps2_clk_sync[1:0], ps2_clk};
      ps2_data_sync <= {ps2_data_sync[0], ps2_data};
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fe && !ps2_data_sync[1]) begin
            state  <= RECV;
            bitcnt <= '0;
          end
        end
        RECV: begin
          if (fe) begin
            shreg  <= {ps2_data_sync[1], shreg[SW-1:1]};
            bitcnt <= bitcnt + BCW'(1);
            tcnt   <= '0;
            if (bitcnt == BCW'(9)) state <= DONE;
          end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon a stalled partial frame.
            state  <= IDLE;
            bitcnt <= '0;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          tcnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO next-state: push/pop arbitration, count and next head byte.
  always_comb begin
    pop_do     = 1'b0;
    push_req   = 1'b0;
    push_do    = 1'b0;
    ovf_set    = 1'b0;
    perr_set   = 1'b0;
    count_next = count;
    rptr_next  = rptr;
    head_next  = data_q;

    pop_do   = !bus.rdn && (count != '0);
    push_req = (state == DONE) && shreg[9] && parity_ok;
    perr_set = (state == DONE) && shreg[9] && !parity_ok;
    // A full FIFO only accepts a push when a pop frees a slot in the same cycle.
    push_do  = push_req && ((count != CW'(DEPTH)) || pop_do);
    ovf_set  = push_req && !push_do;

    case ({push_do, pop_do})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    if (pop_do) rptr_next = rptr + FIFO_AW'(1);

    // The byte being written is the new head when it lands at the read slot.
    if (push_do && (rptr_next == wptr)) head_next = shreg[BW-1:0];
    else                                head_next = mem[rptr_next];
  end

  // FIFO storage (no reset needed; guarded by count).
  always_ff @(posedge clk) begin
    if (push_do) mem[wptr] <= shreg[BW-1:0];
  end

  // FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (push_do) wptr <= wptr + FIFO_AW'(1);
      rptr    <= rptr_next;
      count   <= count_next;
      ready_q <= (count_next != '0);
      if (count_next != '0) data_q <= head_next;
      if (ovf_set)     overflow_q <= 1'b1;
      else if (pop_do) overflow_q <= 1'b0;
      if (perr_set)    perr_q <= 1'b1;
      else if (pop_do) perr_q <= 1'b0;
    end
  end

  assign bus.data     = data_q;
  assign bus.ready    = ready_q;
  assign bus.overflow = overflow_q;
`ifdef PS2_PARITY_CHK_EN
  assign bus.parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed + randomized bench for ps2_rx_fifo with a
// queue-based reference model of the receive FIFO.
module tb_ps2_rx_fifo;

  localparam int unsigned FIFO_AW = 3;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TO      = 200;
  localparam int unsigned HALF    = 8;

  logic clk = 1'b0;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_fifo_if bus_if ();

  ps2_rx_fifo #(.FIFO_AW(FIFO_AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       m_ovf  = 1'b0;
  logic       m_perr = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ready"},    32'(bus_if.ready),    32'(q.size() != 0));
    chk({tag, ".data"},     32'(bus_if.data),     32'(m_data));
    chk({tag, ".overflow"}, 32'(bus_if.overflow), 32'(m_ovf));
`ifdef PS2_PARITY_CHK_EN
    chk({tag, ".parity_err"}, 32'(bus_if.parity_err), 32'(m_perr));
`endif
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_good, input bit stop);
    logic par;
    par = par_good ? ~^b : ^b;
    return {stop, par, b, 1'b0};
  endfunction

  // Reference model: what a completed frame does to the FIFO.
  task automatic model_frame(input logic [7:0] b, input bit par_good, input bit stop);
    if (stop) begin
`ifdef PS2_PARITY_CHK_EN
      if (!par_good) m_perr = 1'b1;
      else
`endif
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else                   q.push_back(b);
    end
    if (q.size() != 0) m_data = q[0];
  endtask

  task automatic model_pop();
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      if (q.size() != 0) m_data = q[0];
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_data = 8'h00;
  endtask

  // Drive the first nbits of a frame; optionally time the stop-bit push.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit lat_chk);
    logic [7:0] b;
    b = f[8:1];
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (lat_chk && i == 10) begin
        repeat (3) @(posedge clk);
        #1;
        chk("lat.early", 32'(bus_if.ready), 32'(0));
        @(posedge clk);
        #1;
        chk("lat.ready", 32'(bus_if.ready), 32'(1));
        chk("lat.data",  32'(bus_if.data),  32'(b));
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_good, input bit stop, input bit lat_chk);
    send_bits(mk_frame(b, par_good, stop), 11, lat_chk);
    model_frame(b, par_good, stop);
  endtask

  task automatic do_pop(input string tag);
    @(negedge clk);
    bus_if.rdn = 1'b0;
    @(negedge clk);
    bus_if.rdn = 1'b1;
    model_pop();
    check_state(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         rstop;
    bit         rpar;
    int         npop;

    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    bus_if.rdn = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset");
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame with push latency, then one pop.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
    check_state("f1c");
    do_pop("f1c.pop");

    // Ordering of two bytes, then pop on empty.
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_state("two");
    do_pop("two.pop1");
    do_pop("two.pop2");
    do_pop("two.empty_pop");

    // Overflow with default depth.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
      check_state($sformatf("fill%0d", i));
    end
    for (int i = 1; i <= 8; i++) do_pop($sformatf("drain%0d", i));
    do_pop("drain.empty");

    // Partial frame abandoned by timeout, then a complete frame.
    send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 5, 1'b0);
    repeat (TO + 50) @(negedge clk);
    check_state("timeout.idle");
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check_state("timeout.5a");
    do_pop("timeout.pop");

    // Bad stop bit is discarded; bad parity depends on the build.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_state("badstop");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("badpar");
    do_pop("badpar.pop");

    // Reset in the middle of a frame.
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    send_bits(mk_frame(8'hC3, 1'b1, 1'b1), 5, 1'b0);
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("rst.hold");
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    check_state("rst.after");
    send_frame(8'h76, 1'b1, 1'b1, 1'b0);
    check_state("rst.76");
    do_pop("rst.pop");

    // Randomized frames and pops against the model.
    for (int it = 0; it < 24; it++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rpar  = ($urandom_range(0, 7) != 0);
      send_frame(rb, rpar, rstop, 1'b0);
      check_state($sformatf("rnd%0d", it));
      npop = int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) do_pop($sformatf("rnd%0d.pop%0d", it, p));
    end
    for (int i = 0; i < DEPTH + 1; i++) do_pop($sformatf("final%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
